// File: rtl/k053327_io_responder.sv
// k053327 I/O window responder: input/DIP reads, ctrl/sound-command writes, sound IRQ pulse; reads valid 1 clk after IOCS falls, no backpressure.
// Optional watchdog built only when WATCHDOG_EN is defined; otherwise wdt_reset is tied low.
module k053327_io_responder #(
  parameter int IRQ_CYCLES = 32,
  parameter int WDT_CYCLES = 2**20,
  parameter int WDT_PULSE  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iocs_n,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_oe,
  input  logic [7:0] in_sys,
  input  logic [7:0] in_p1,
  input  logic [7:0] in_p2,
  input  logic [7:0] dsw1,
  input  logic [7:0] dsw2,
  input  logic [7:0] dsw3,
  output logic [7:0] ctrl,
  output logic [7:0] sound_cmd,
  output logic       sound_irq,
  output logic       wdt_reset
);

  if (IRQ_CYCLES < 1 || IRQ_CYCLES > 255) begin : g_bad_irq_cfg
    $error("IRQ_CYCLES must be within 1..255");
  end
  if (WDT_CYCLES < 2 || WDT_PULSE < 1) begin : g_bad_wdt_cfg
    $error("WDT_CYCLES must be >= 2 and WDT_PULSE >= 1");
  end

  logic       cs_q;
  logic       start;
  logic       rd_stb;
  logic       wr_stb;
  logic [7:0] rd_mux;
  logic [7:0] irq_cnt;

  // One strobe per low period of iocs_n: cs_q is the previous-cycle select level.
  assign start   = ~iocs_n & cs_q;
  assign rd_stb  = start & rw;
  assign wr_stb  = start & ~rw;
  assign dout_oe = rw & ~cs_q;

  always_comb begin
    rd_mux = 8'hFF;
    case (addr)
      4'h0:    rd_mux = in_sys;
      4'h1:    rd_mux = in_p1;
      4'h2:    rd_mux = in_p2;
      4'h3:    rd_mux = dsw3;
      4'h4:    rd_mux = dsw1;
      4'h5:    rd_mux = dsw2;
      default: rd_mux = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q      <= 1'b1;
      dout      <= 8'hFF;
      ctrl      <= 8'h00;
      sound_cmd <= 8'h00;
      sound_irq <= 1'b0;
      irq_cnt   <= 8'h00;
    end else begin
      cs_q <= iocs_n;
      if (rd_stb) dout <= rd_mux;
      if (wr_stb && addr == 4'h8) ctrl <= din;
      // A command write restarts the pulse with no gap, even mid-pulse.
      if (wr_stb && addr == 4'hC) begin
        sound_cmd <= din;
        sound_irq <= 1'b1;
        irq_cnt   <= 8'(IRQ_CYCLES - 1);
      end else if (sound_irq) begin
        if (irq_cnt == 8'h00) sound_irq <= 1'b0;
        else                  irq_cnt   <= irq_cnt - 8'h01;
      end
    end
  end

`ifdef WATCHDOG_EN
  localparam int WDT_W = ($clog2(WDT_CYCLES) > 20) ? $clog2(WDT_CYCLES) : 20;
  localparam int PLS_W = $clog2(WDT_PULSE + 1);

  logic             kick;
  logic [WDT_W-1:0] wdt_cnt;
  logic [PLS_W-1:0] pulse_cnt;

  assign kick = wr_stb && addr == 4'h0;

  // The timeout counter is held at zero while the pulse runs, then restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt   <= '0;
      pulse_cnt <= '0;
      wdt_reset <= 1'b0;
    end else begin
      if (wdt_reset) begin
        if (pulse_cnt == PLS_W'(1)) wdt_reset <= 1'b0;
        pulse_cnt <= pulse_cnt - PLS_W'(1);
      end
      if (kick || wdt_reset) begin
        wdt_cnt <= '0;
      end else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
        wdt_cnt   <= '0;
        wdt_reset <= 1'b1;
        pulse_cnt <= PLS_W'(WDT_PULSE);
      end else begin
        wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
    end
  end
`else
  assign wdt_reset = 1'b0;
`endif

endmodule

// File: tb/tb_k053327_io_responder.sv
// Scoreboard bench for k053327_io_responder: stimulus queues expected read data and IRQ pulse lengths,
// a monitor pops and compares them when dout_oe rises or sound_irq falls.
module tb_k053327_io_responder;

  localparam int IRQ_CYCLES = 32;
  localparam int WDT_CYCLES = 100;
  localparam int WDT_PULSE  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       iocs_n = 1'b1;
  logic       rw = 1'b1;
  logic [3:0] addr = 4'h0;
  logic [7:0] din = 8'h00;
  logic [7:0] in_sys = 8'h11, in_p1 = 8'h5A, in_p2 = 8'h33;
  logic [7:0] dsw1 = 8'h44, dsw2 = 8'h55, dsw3 = 8'h66;
  logic [7:0] dout, ctrl, sound_cmd;
  logic       dout_oe, sound_irq, wdt_reset;

  int n_checks = 0;
  int n_fail   = 0;
  int wdt_hi   = 0;
  logic [7:0] rd_q[$];
  int         irq_q[$];

  k053327_io_responder #(
    .IRQ_CYCLES(IRQ_CYCLES), .WDT_CYCLES(WDT_CYCLES), .WDT_PULSE(WDT_PULSE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .iocs_n(iocs_n), .rw(rw), .addr(addr), .din(din),
    .dout(dout), .dout_oe(dout_oe), .in_sys(in_sys), .in_p1(in_p1), .in_p2(in_p2),
    .dsw1(dsw1), .dsw2(dsw2), .dsw3(dsw3), .ctrl(ctrl), .sound_cmd(sound_cmd),
    .sound_irq(sound_irq), .wdt_reset(wdt_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  initial begin
    logic poe, pirq;
    int   hi;
    poe = 1'b0; pirq = 1'b0; hi = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        poe = 1'b0; pirq = 1'b0; hi = 0;
      end else begin
        if (dout_oe && !poe) begin
          if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
          else                  check("rd_data", 32'(dout), 32'(rd_q.pop_front()));
        end
        poe = dout_oe;
        if (sound_irq) hi++;
        else if (pirq) begin
          if (irq_q.size() == 0) check("irq_unexpected", 32'd1, 32'd0);
          else                   check("irq_len", 32'(hi), 32'(irq_q.pop_front()));
          hi = 0;
        end
        pirq = sound_irq;
        if (wdt_reset) wdt_hi++;
      end
    end
  end

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input int hold, input bit chg);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b1; addr = a;
    rd_q.push_back(exp);
    @(negedge clk);
    if (chg) in_p1 = 8'h00;
    repeat (hold) @(negedge clk);
    check("oe_active", 32'(dout_oe), 32'd1);
    iocs_n = 1'b1;
    #1 check("oe_after_rise", 32'(dout_oe), 32'd1);
    @(posedge clk); #1;
    check("oe_drop", 32'(dout_oe), 32'd0);
    check("dout_idle_hold", 32'(dout), 32'(exp));
    if (chg) in_p1 = 8'h5A;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input int hold, input bit scr);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b0; addr = a; din = d;
    @(negedge clk);
    if (scr) din = 8'h00;
    repeat (hold) @(negedge clk);
    iocs_n = 1'b1;
  endtask

  logic [3:0] ra[10];
  logic [7:0] re[10];

  initial begin
    ra = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF};
    re = '{8'h11, 8'h5A, 8'h33, 8'h66, 8'h44, 8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    #2 reset_n = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 32'hFF);
    check("rst_oe", 32'(dout_oe), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'h00);
    check("rst_cmd", 32'(sound_cmd), 32'h00);
    check("rst_irq", 32'(sound_irq), 32'd0);
    check("rst_wdt", 32'(wdt_reset), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

`ifdef WATCHDOG_EN
    for (int n = 1; n <= 130; n++) begin
      @(posedge clk); #1;
      check("wdt_pulse", 32'(wdt_reset), 32'((n >= WDT_CYCLES && n < WDT_CYCLES + WDT_PULSE) ? 1 : 0));
    end
    wdt_hi = 0;
    for (int k = 0; k < 6; k++) begin
      wr(4'h0, 8'h00, 0, 1'b0);
      repeat (48) @(negedge clk);
    end
    check("wdt_kicked_quiet", 32'(wdt_hi), 32'd0);
`else
    wdt_hi = 0;
`endif

    // Reads across the address map; a long hold with changing input must not retrigger.
    for (int i = 0; i < 10; i++) rd(ra[i], re[i], 1, 1'b0);
    rd(4'h1, 8'h5A, 4, 1'b1);

    wr(4'h8, 8'hA5, 0, 1'b0);
    check("ctrl_write", 32'(ctrl), 32'hA5);
    wr(4'h8, 8'h03, 3, 1'b1);
    check("ctrl_din_late_ignored", 32'(ctrl), 32'h03);

    irq_q.push_back(IRQ_CYCLES);
    wr(4'hC, 8'h42, 0, 1'b0);
    check("cmd_write", 32'(sound_cmd), 32'h42);
    check("irq_set", 32'(sound_irq), 32'd1);
    repeat (40) @(negedge clk);

    irq_q.push_back(10 + IRQ_CYCLES);
    wr(4'hC, 8'h42, 0, 1'b0);
    repeat (8) @(negedge clk);
    wr(4'hC, 8'h43, 0, 1'b0);
    check("cmd_rewrite", 32'(sound_cmd), 32'h43);
    repeat (50) @(negedge clk);

    wr(4'h5, 8'hAA, 1, 1'b0);
    wr(4'h0, 8'hBB, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("ign_ctrl", 32'(ctrl), 32'h03);
    check("ign_cmd", 32'(sound_cmd), 32'h43);
    check("ign_irq", 32'(sound_irq), 32'd0);

    // Reset in the middle of an IRQ pulse and an ongoing read.
    wr(4'hC, 8'h55, 0, 1'b0);
    @(negedge clk);
    iocs_n = 1'b0; rw = 1'b1; addr = 4'h2;
    rd_q.push_back(8'h33);
    repeat (2) @(negedge clk);
    check("mid_oe", 32'(dout_oe), 32'd1);
    check("mid_irq", 32'(sound_irq), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_irq", 32'(sound_irq), 32'd0);
    check("arst_oe", 32'(dout_oe), 32'd0);
    check("arst_dout", 32'(dout), 32'hFF);
    check("arst_ctrl", 32'(ctrl), 32'h00);
    check("arst_cmd", 32'(sound_cmd), 32'h00);
    repeat (2) @(negedge clk);
    // iocs_n still low at release: exactly one access on the first edge.
    rd_q.push_back(8'h33);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_oe", 32'(dout_oe), 32'd1);
    check("post_rst_dout", 32'(dout), 32'h33);
    check("post_rst_irq", 32'(sound_irq), 32'd0);
    iocs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_oe_drop", 32'(dout_oe), 32'd0);

    repeat (5) @(negedge clk);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("irq_queue_drained", 32'(irq_q.size()), 32'd0);
`ifndef WATCHDOG_EN
    check("wdt_never", 32'(wdt_hi), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
